mem_loader: RTL and testbench

MEM_LOADER -- requirements
Module: mem_loader

---
 rtl/mem_loader_pkg.sv | 17 +
 rtl/mem_loader_ram.sv | 45 ++++
 rtl/mem_loader.sv | 163 ++++++++++++++++
 tb/tb_mem_loader.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_loader_pkg.sv
// mem_loader_pkg: shared state encoding and default widths for mem_loader.
// Contents:
//   DEF_DATA_W, DEF_ADDR_W, DEF_BASE_ADDR  default parameter values
//   state_e                                load-session state encoding
package mem_loader_pkg;

  localparam int unsigned DEF_DATA_W    = 16;
  localparam int unsigned DEF_ADDR_W    = 9;
  localparam int unsigned DEF_BASE_ADDR = 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/mem_loader_ram.sv
// ml_ram: single write port, registered read port word memory.
// Ports:
//   clk, rst_n        clock, async active-low reset (read register only)
//   we, waddr, wdata  write port, written on the rising edge
//   re, raddr         read request; rdata updates one cycle later
//   rdata             read word, holds while re is low
// The array itself is never reset so contents survive a reset.
module ml_ram #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned ADDR_W = 9
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  localparam int unsigned DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] rdata_d, rdata_q;

  // Write port
  always_ff @(posedge clk) begin
    if (we) mem_q[waddr] <= wdata;
  end

  // Read register holds its value when no read is requested
  always_comb begin
    rdata_d = rdata_q;
    if (re) rdata_d = mem_q[raddr];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rdata_q <= '0;
    else        rdata_q <= rdata_d;
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/mem_loader.sv
// mem_loader: streams load words into a memory starting at BASE_ADDR and
// serves single-cycle-latency reads while idle.
// Ports:
//   clock, reset_n                    clock, async active-low reset
//   load_start                        begin a load session (IDLE only)
//   load_valid/load_data/load_last    load stream, accepted when load_ready
//   load_ready, load_done, load_count handshake, end pulse, words written
//   overflow                          sticky: beat offered with memory full
//   rd_req/rd_addr -> rd_valid/rd_data read port, IDLE only
//   busy                              state is not IDLE
//   checksum                          only with MEM_LOADER_CHECKSUM_EN defined:
//                                     sum of written words mod 2**DATA_W
module mem_loader
  import mem_loader_pkg::*;
#(
  parameter int unsigned DATA_W    = DEF_DATA_W,
  parameter int unsigned ADDR_W    = DEF_ADDR_W,
  parameter int unsigned BASE_ADDR = DEF_BASE_ADDR
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              load_start,
  input  logic              load_valid,
  input  logic [DATA_W-1:0] load_data,
  input  logic              load_last,
  output logic              load_ready,
  output logic              load_done,
  output logic [ADDR_W:0]   load_count,
  output logic              overflow,
  input  logic              rd_req,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic              rd_valid,
  output logic [DATA_W-1:0] rd_data,
`ifdef MEM_LOADER_CHECKSUM_EN
  output logic [DATA_W-1:0] checksum,
`endif
  output logic              busy
);

  localparam int unsigned CNT_W     = ADDR_W + 1;
  localparam int unsigned DEPTH     = 1 << ADDR_W;
  localparam logic [ADDR_W:0]   DEPTH_CNT = CNT_W'(DEPTH);
  localparam logic [ADDR_W-1:0] BASE_PTR  = ADDR_W'(BASE_ADDR);

  state_e              state_d, state_q;
  logic [ADDR_W-1:0]   ptr_d, ptr_q;
  logic [ADDR_W:0]     count_d, count_q;
  logic                overflow_d, overflow_q;
  logic                load_ready_d, load_ready_q;
  logic                load_done_d, load_done_q;
  logic                busy_d, busy_q;
  logic                rd_valid_d, rd_valid_q;
  logic                we_c, re_c;
`ifdef MEM_LOADER_CHECKSUM_EN
  logic [DATA_W-1:0]   checksum_d, checksum_q;
`endif

  // Next state, write/read strobes and registered output values
  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    count_d    = count_q;
    overflow_d = overflow_q;
    we_c       = 1'b0;
    re_c       = 1'b0;
`ifdef MEM_LOADER_CHECKSUM_EN
    checksum_d = checksum_q;
`endif
    case (state_q)
      ST_IDLE: begin
        re_c = rd_req;
        if (load_start) begin
          state_d    = ST_LOAD;
          ptr_d      = BASE_PTR;
          count_d    = '0;
          overflow_d = 1'b0;
`ifdef MEM_LOADER_CHECKSUM_EN
          checksum_d = '0;
`endif
        end
      end
      ST_LOAD: begin
        if (load_valid && load_ready_q) begin
          // Pointer wraps naturally at DEPTH through its ADDR_W width
          we_c    = 1'b1;
          ptr_d   = ptr_q + ADDR_W'(1);
          count_d = count_q + CNT_W'(1);
`ifdef MEM_LOADER_CHECKSUM_EN
          checksum_d = checksum_q + load_data;
`endif
          if (load_last) state_d = ST_DONE;
        end else if (load_valid && (count_q == DEPTH_CNT)) begin
          // Memory full: drop the beat, flag it, still honour load_last
          overflow_d = 1'b1;
          if (load_last) state_d = ST_DONE;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    // Flag outputs are computed from the next state so they are registered
    load_ready_d = (state_d == ST_LOAD) && (count_d < DEPTH_CNT);
    load_done_d  = (state_d == ST_DONE);
    busy_d       = (state_d != ST_IDLE);
    rd_valid_d   = re_c;
  end

  // State and control registers
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= ST_IDLE;
      ptr_q        <= BASE_PTR;
      count_q      <= '0;
      overflow_q   <= 1'b0;
      load_ready_q <= 1'b0;
      load_done_q  <= 1'b0;
      busy_q       <= 1'b0;
      rd_valid_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      ptr_q        <= ptr_d;
      count_q      <= count_d;
      overflow_q   <= overflow_d;
      load_ready_q <= load_ready_d;
      load_done_q  <= load_done_d;
      busy_q       <= busy_d;
      rd_valid_q   <= rd_valid_d;
    end
  end

`ifdef MEM_LOADER_CHECKSUM_EN
  // Running checksum of written words
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) checksum_q <= '0;
    else          checksum_q <= checksum_d;
  end

  assign checksum = checksum_q;
`endif

  ml_ram #(
    .DATA_W(DATA_W),
    .ADDR_W(ADDR_W)
  ) u_ram (
    .clk   (clock),
    .rst_n (reset_n),
    .we    (we_c),
    .waddr (ptr_q),
    .wdata (load_data),
    .re    (re_c),
    .raddr (rd_addr),
    .rdata (rd_data)
  );

  assign load_ready = load_ready_q;
  assign load_done  = load_done_q;
  assign load_count = count_q;
  assign overflow   = overflow_q;
  assign busy       = busy_q;
  assign rd_valid   = rd_valid_q;

endmodule

// File: tb/tb_mem_loader.sv
// tb_mem_loader: self-checking bench for mem_loader. Two instances: a default
// one (DATA_W 16, ADDR_W 9, BASE_ADDR 1) and a small one (ADDR_W 3,
// BASE_ADDR 6) for wrap and overflow. Read results go through per-instance
// scoreboard queues filled when a read is issued. Honours
// MEM_LOADER_CHECKSUM_EN.
module tb_mem_loader;

  logic clock = 1'b0;
  logic reset_n = 1'b0;
  always #5 clock = ~clock;

  int total = 0;
  int bad   = 0;

  // Default instance
  logic        load_start = 0, load_valid = 0, load_last = 0, rd_req = 0;
  logic [15:0] load_data = '0;
  logic [8:0]  rd_addr = '0;
  logic        load_ready, load_done, overflow, rd_valid, busy;
  logic [9:0]  load_count;
  logic [15:0] rd_data;
`ifdef MEM_LOADER_CHECKSUM_EN
  logic [15:0] checksum, b_checksum;
`endif

  // Small instance
  logic        b_load_start = 0, b_load_valid = 0, b_load_last = 0, b_rd_req = 0;
  logic [15:0] b_load_data = '0;
  logic [2:0]  b_rd_addr = '0;
  logic        b_load_ready, b_load_done, b_overflow, b_rd_valid, b_busy;
  logic [3:0]  b_load_count;
  logic [15:0] b_rd_data;

  mem_loader dut0 (
    .clock(clock), .reset_n(reset_n), .load_start(load_start),
    .load_valid(load_valid), .load_data(load_data), .load_last(load_last),
    .load_ready(load_ready), .load_done(load_done), .load_count(load_count),
    .overflow(overflow), .rd_req(rd_req), .rd_addr(rd_addr),
    .rd_valid(rd_valid), .rd_data(rd_data),
`ifdef MEM_LOADER_CHECKSUM_EN
    .checksum(checksum),
`endif
    .busy(busy)
  );

  mem_loader #(.DATA_W(16), .ADDR_W(3), .BASE_ADDR(6)) dut1 (
    .clock(clock), .reset_n(reset_n), .load_start(b_load_start),
    .load_valid(b_load_valid), .load_data(b_load_data), .load_last(b_load_last),
    .load_ready(b_load_ready), .load_done(b_load_done), .load_count(b_load_count),
    .overflow(b_overflow), .rd_req(b_rd_req), .rd_addr(b_rd_addr),
    .rd_valid(b_rd_valid), .rd_data(b_rd_data),
`ifdef MEM_LOADER_CHECKSUM_EN
    .checksum(b_checksum),
`endif
    .busy(b_busy)
  );

  // Reference memory contents and write pointers
  logic [15:0] model0 [512];
  logic [15:0] model1 [8];
  int ptr0 = 1;
  logic [15:0] q0[$];
  logic [15:0] q1[$];

  // Read scoreboards: every rd_valid must match an issued read
  always @(posedge clock) begin
    #2;
    if (rd_valid === 1'b1) begin
      total++;
      if (q0.size() == 0) begin
        bad++;
        $display("FAIL rd0_unexpected: rd_valid=1 data=%h, no read pending", rd_data);
      end else begin
        logic [15:0] e;
        e = q0.pop_front();
        if (rd_data !== e) begin
          bad++;
          $display("FAIL rd0_data: got %h expected %h", rd_data, e);
        end
      end
    end
    if (b_rd_valid === 1'b1) begin
      total++;
      if (q1.size() == 0) begin
        bad++;
        $display("FAIL rd1_unexpected: rd_valid=1 data=%h, no read pending", b_rd_data);
      end else begin
        logic [15:0] e;
        e = q1.pop_front();
        if (b_rd_data !== e) begin
          bad++;
          $display("FAIL rd1_data: got %h expected %h", b_rd_data, e);
        end
      end
    end
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic start0();
    load_start = 1'b1;
    ptr0 = 1;
    step();
    load_start = 1'b0;
  endtask

  // Offer one beat to dut0, waiting (bounded) for load_ready
  task automatic beat0(input logic [15:0] d, input logic last);
    int n;
    n = 0;
    load_valid = 1'b1;
    load_data  = d;
    load_last  = last;
    while (load_ready !== 1'b1 && n < 50) begin
      step();
      n++;
    end
    if (load_ready !== 1'b1) begin
      total++;
      bad++;
      $display("FAIL beat0_timeout: load_ready=%b required 1", load_ready);
    end
    model0[ptr0] = d;
    ptr0 = (ptr0 + 1) % 512;
    step();
    load_valid = 1'b0;
    load_last  = 1'b0;
  endtask

  task automatic rd0(input logic [8:0] a);
    rd_req  = 1'b1;
    rd_addr = a;
    q0.push_back(model0[a]);
    step();
    rd_req = 1'b0;
  endtask

  task automatic rd1(input logic [2:0] a);
    b_rd_req  = 1'b1;
    b_rd_addr = a;
    q1.push_back(model1[a]);
    step();
    b_rd_req = 1'b0;
  endtask

  task automatic test_reset();
    repeat (3) step();
    total++; if (busy !== 1'b0)       begin bad++; $display("FAIL rst_busy: got %b need 0", busy); end
    total++; if (load_ready !== 1'b0) begin bad++; $display("FAIL rst_ready: got %b need 0", load_ready); end
    total++; if (load_done !== 1'b0)  begin bad++; $display("FAIL rst_done: got %b need 0", load_done); end
    total++; if (load_count !== 10'd0) begin bad++; $display("FAIL rst_count: got %0d need 0", load_count); end
    total++; if (overflow !== 1'b0)   begin bad++; $display("FAIL rst_ovf: got %b need 0", overflow); end
    total++; if (rd_valid !== 1'b0)   begin bad++; $display("FAIL rst_rdv: got %b need 0", rd_valid); end
    total++; if (rd_data !== 16'h0)   begin bad++; $display("FAIL rst_rdd: got %h need 0", rd_data); end
    reset_n = 1'b1;
    step();
  endtask

  task automatic test_load4();
    start0();
    total++; if (busy !== 1'b1)       begin bad++; $display("FAIL l4_busy: got %b need 1", busy); end
    total++; if (load_ready !== 1'b1) begin bad++; $display("FAIL l4_ready: got %b need 1", load_ready); end
    beat0(16'd10, 1'b0);
    beat0(16'd20, 1'b0);
    beat0(16'd30, 1'b0);
    beat0(16'd40, 1'b1);
    total++; if (load_done !== 1'b1)  begin bad++; $display("FAIL l4_done: got %b need 1", load_done); end
    total++; if (load_count !== 10'd4) begin bad++; $display("FAIL l4_count: got %0d need 4", load_count); end
    total++; if (load_ready !== 1'b0) begin bad++; $display("FAIL l4_ready_done: got %b need 0", load_ready); end
    step();
    total++; if (load_done !== 1'b0)  begin bad++; $display("FAIL l4_done_pulse: got %b need 0", load_done); end
    total++; if (busy !== 1'b0)       begin bad++; $display("FAIL l4_idle: got %b need 0", busy); end
    total++; if (load_count !== 10'd4) begin bad++; $display("FAIL l4_count_hold: got %0d need 4", load_count); end
    for (int a = 1; a <= 4; a++) rd0(9'(a));
    step();
  endtask

  task automatic test_back_to_back_read();
    rd0(9'd1);
    rd0(9'd2);
    total++; if (rd_valid !== 1'b1)  begin bad++; $display("FAIL b2b_valid: got %b need 1", rd_valid); end
    total++; if (rd_data !== 16'd20) begin bad++; $display("FAIL b2b_data: got %h need 0014", rd_data); end
    step();
    total++; if (rd_valid !== 1'b0)  begin bad++; $display("FAIL b2b_valid_low: got %b need 0", rd_valid); end
    total++; if (rd_data !== 16'd20) begin bad++; $display("FAIL b2b_hold: got %h need 0014", rd_data); end
    // Read during LOAD is ignored
    start0();
    rd_req = 1'b1;
    rd_addr = 9'd1;
    step();
    rd_req = 1'b0;
    total++; if (rd_valid !== 1'b0)  begin bad++; $display("FAIL rd_in_load: got %b need 0", rd_valid); end
    beat0(16'h0BEE, 1'b1);
    step();
    rd0(9'd1);
    step();
  endtask

  task automatic test_toggle();
    start0();
    for (int i = 0; i < 5; i++) begin
      beat0(16'h0100 + 16'(i), i == 4);
      if (i < 4) step();
    end
    total++; if (load_done !== 1'b1)  begin bad++; $display("FAIL tg_done: got %b need 1", load_done); end
    total++; if (load_count !== 10'd5) begin bad++; $display("FAIL tg_count: got %0d need 5", load_count); end
    step();
    for (int a = 1; a <= 5; a++) rd0(9'(a));
    step();
  endtask

  task automatic test_reset_mid();
    start0();
    beat0(16'hAAAA, 1'b0);
    beat0(16'hBBBB, 1'b0);
    load_valid = 1'b1;
    load_data  = 16'hCCCC;
    reset_n    = 1'b0;
    #1;
    total++; if (busy !== 1'b0)       begin bad++; $display("FAIL rm_busy: got %b need 0", busy); end
    total++; if (load_ready !== 1'b0) begin bad++; $display("FAIL rm_ready: got %b need 0", load_ready); end
    total++; if (load_count !== 10'd0) begin bad++; $display("FAIL rm_count: got %0d need 0", load_count); end
    total++; if (rd_data !== 16'h0)   begin bad++; $display("FAIL rm_rdd: got %h need 0", rd_data); end
    load_valid = 1'b0;
    step();
    reset_n = 1'b1;
    step();
    rd0(9'd1);
    rd0(9'd2);
    step();
  endtask

  task automatic test_overflow();
    b_load_start = 1'b1;
    step();
    b_load_start = 1'b0;
    for (int i = 0; i < 9; i++) begin
      b_load_valid = 1'b1;
      b_load_data  = 16'd100 + 16'(i);
      b_load_last  = (i == 8);
      if (i < 8) begin
        total++;
        if (b_load_ready !== 1'b1) begin bad++; $display("FAIL ov_ready%0d: got %b need 1", i, b_load_ready); end
        model1[(6 + i) % 8] = 16'd100 + 16'(i);
      end else begin
        total++;
        if (b_load_ready !== 1'b0) begin bad++; $display("FAIL ov_full_ready: got %b need 0", b_load_ready); end
      end
      step();
    end
    b_load_valid = 1'b0;
    b_load_last  = 1'b0;
    total++; if (b_overflow !== 1'b1)    begin bad++; $display("FAIL ov_flag: got %b need 1", b_overflow); end
    total++; if (b_load_count !== 4'd8)  begin bad++; $display("FAIL ov_count: got %0d need 8", b_load_count); end
    total++; if (b_load_done !== 1'b1)   begin bad++; $display("FAIL ov_done: got %b need 1", b_load_done); end
    step();
    total++; if (b_overflow !== 1'b1)    begin bad++; $display("FAIL ov_sticky: got %b need 1", b_overflow); end
    total++; if (b_busy !== 1'b0)        begin bad++; $display("FAIL ov_idle: got %b need 0", b_busy); end
    for (int a = 0; a < 8; a++) rd1(3'(a));
    step();
  endtask

`ifdef MEM_LOADER_CHECKSUM_EN
  task automatic test_checksum();
    start0();
    beat0(16'hFFFF, 1'b0);
    beat0(16'h0002, 1'b1);
    total++; if (checksum !== 16'h0001) begin bad++; $display("FAIL cks: got %h need 0001", checksum); end
    step();
  endtask
`endif

  initial begin
    test_reset();
    test_load4();
    test_back_to_back_read();
    test_toggle();
    test_reset_mid();
    test_overflow();
`ifdef MEM_LOADER_CHECKSUM_EN
    test_checksum();
`endif
    repeat (3) step();
    total++; if (q0.size() != 0) begin bad++; $display("FAIL rd0_missing: %0d reads unanswered, need 0", q0.size()); end
    total++; if (q1.size() != 0) begin bad++; $display("FAIL rd1_missing: %0d reads unanswered, need 0", q1.size()); end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
